tc_pl_gset_relay_drv: RTL and testbench

Responder side of the gain-set handshake. Accepts a gain-set request (gset_en plus target relay code gset_relay) from the capture gain controller, drives the latching-relay set/reset coils to reach the target, waits a settle time, then returns gset_relay_cmpt. Sits between the capture gain controller and the front-end relay driver pins.

---
 rtl/tc_pl_cap_pkg.sv | 16 +
 rtl/tc_pl_gset_relay_drv_if.sv | 12 +
 rtl/tc_pl_pulse_timer.sv | 27 ++
 rtl/tc_pl_gset_relay_drv.sv | 190 +++++++++++++++++++
 tb/tb_tc_pl_gset_relay_drv.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tc_pl_cap_pkg.sv
// Shared capture-path definitions: gain-set FSM state encoding and default widths,
// used by both the capture gain controller and the relay driver.
package tc_pl_cap_pkg;

    localparam int CAP0_14_DEF = 4;   // number of relays
    localparam int CAP0_2_DEF  = 32;  // pulse/settle counter width

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_PULSE  = 3'd2,
        S_SETTLE = 3'd3,
        S_CMPT   = 3'd4
    } gset_state_e;

endpackage

// File: rtl/tc_pl_gset_relay_drv_if.sv
// Gain-set request/complete handshake between the capture gain controller (master)
// and the relay driver (slave).
interface tc_pl_gset_relay_drv_if #(
    parameter int NR = tc_pl_cap_pkg::CAP0_14_DEF
);
    logic          gset_en;
    logic [NR-1:0] gset_relay;
    logic          gset_relay_cmpt;

    modport master (output gset_en, output gset_relay, input  gset_relay_cmpt);
    modport slave  (input  gset_en, input  gset_relay, output gset_relay_cmpt);
endinterface

// File: rtl/tc_pl_pulse_timer.sv
// Saturating load/count timer; done is asserted while the count has reached limit.
module tc_pl_pulse_timer #(
    parameter int           W     = 32,
    parameter logic [W-1:0] START = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         count_en,
    input  logic [W-1:0] limit,
    output logic         done
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= START;
        end else if (count_en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign done = (cnt_q >= limit);

endmodule

// File: rtl/tc_pl_gset_relay_drv.sv
// Gain-set responder: pulses latching-relay set/reset coils toward a requested code,
// settles, then signals completion. Define TC_RELAY_SEQ_EN to pulse one relay at a time.
//
// state    | meaning
// S_IDLE   | waiting for gset_en; captures target code
// S_LATCH  | computes bits to set/reset, skips coils if nothing changes
// S_PULSE  | coils driven (sequential mode: one bit per pulse, 1-cycle gaps)
// S_SETTLE | coils off, waiting cfg_settle_len cycles
// S_CMPT   | completion reported until gset_en falls
module tc_pl_gset_relay_drv
    import tc_pl_cap_pkg::*;
#(
    parameter int CAP0_14 = CAP0_14_DEF,
    parameter int CAP0_2  = CAP0_2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    tc_pl_gset_relay_drv_if.slave gset_if,
    input  logic [CAP0_2-1:0]     cfg_pulse_len,
    input  logic [CAP0_2-1:0]     cfg_settle_len,
    output logic [CAP0_14-1:0]    relay_set,
    output logic [CAP0_14-1:0]    relay_rst,
    output logic [CAP0_14-1:0]    relay_state,
    output logic                  relay_valid
);
    gset_state_e        state_q, state_d;
    logic [CAP0_14-1:0] req_q, req_d;
    logic [CAP0_14-1:0] up_q, up_d, dn_q, dn_d;
    logic [CAP0_14-1:0] rstate_q, rstate_d;
    logic               valid_q, valid_d;
    logic [CAP0_14-1:0] tgt_up, tgt_dn, drive_sel;
    logic [CAP0_2-1:0]  p_len;
    logic               p_load, p_en, p_done;
    logic               s_load, s_en, s_done;
    logic               en;

    assign en     = gset_if.gset_en;
    assign p_len  = (cfg_pulse_len == '0) ? CAP0_2'(1) : cfg_pulse_len;
    // Unknown relay position: drive every bit toward the target.
    assign tgt_up = valid_q ? (req_q & ~rstate_q) : req_q;
    assign tgt_dn = valid_q ? (~req_q & rstate_q) : ~req_q;

`ifdef TC_RELAY_SEQ_EN
    logic [CAP0_14-1:0] pend_q, pend_d, cur_bit;
    logic               gap_q, gap_d;

    assign cur_bit   = pend_q & (~pend_q + 1'b1);
    assign drive_sel = gap_q ? '0 : cur_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
            gap_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            gap_q  <= gap_d;
        end
    end
`else
    assign drive_sel = '1;
`endif

    tc_pl_pulse_timer #(.W(CAP0_2), .START(CAP0_2'(1))) u_pulse_tmr (
        .clk(clk), .rst(rst), .load(p_load), .count_en(p_en),
        .limit(p_len), .done(p_done)
    );

    tc_pl_pulse_timer #(.W(CAP0_2), .START('0)) u_settle_tmr (
        .clk(clk), .rst(rst), .load(s_load), .count_en(s_en),
        .limit(cfg_settle_len), .done(s_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            req_q    <= '0;
            up_q     <= '0;
            dn_q     <= '0;
            rstate_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
            rstate_q <= rstate_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        up_d     = up_q;
        dn_d     = dn_q;
        rstate_d = rstate_q;
        valid_d  = valid_q;
        p_load   = 1'b0;
        p_en     = 1'b0;
        s_load   = 1'b0;
        s_en     = 1'b0;
`ifdef TC_RELAY_SEQ_EN
        pend_d   = pend_q;
        gap_d    = gap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    req_d   = gset_if.gset_relay;
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else begin
                    up_d = tgt_up;
                    dn_d = tgt_dn;
                    if ((tgt_up | tgt_dn) == '0) begin
                        state_d = S_CMPT;
                    end else begin
                        p_load  = 1'b1;
                        state_d = S_PULSE;
`ifdef TC_RELAY_SEQ_EN
                        pend_d  = tgt_up | tgt_dn;
                        gap_d   = 1'b0;
`endif
                    end
                end
            end
            S_PULSE: begin
                if (!en) begin
                    // Aborted mid-drive: relay positions are no longer trustworthy.
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else begin
`ifdef TC_RELAY_SEQ_EN
                    if (gap_q) begin
                        gap_d  = 1'b0;
                        p_load = 1'b1;
                    end else begin
                        p_en = 1'b1;
                        if (p_done) begin
                            pend_d = pend_q & ~cur_bit;
                            if ((pend_q & ~cur_bit) == '0) begin
                                s_load  = 1'b1;
                                state_d = S_SETTLE;
                            end else begin
                                gap_d = 1'b1;
                            end
                        end
                    end
`else
                    p_en = 1'b1;
                    if (p_done) begin
                        s_load  = 1'b1;
                        state_d = S_SETTLE;
                    end
`endif
                end
            end
            S_SETTLE: begin
                if (!en) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else begin
                    s_en = 1'b1;
                    if (s_done) begin
                        rstate_d = req_q;
                        valid_d  = 1'b1;
                        state_d  = S_CMPT;
                    end
                end
            end
            S_CMPT: begin
                if (!en) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign relay_set   = (state_q == S_PULSE) ? (up_q & drive_sel) : '0;
    assign relay_rst   = (state_q == S_PULSE) ? (dn_q & drive_sel) : '0;
    assign relay_state = rstate_q;
    assign relay_valid = valid_q;
    assign gset_if.gset_relay_cmpt = (state_q == S_CMPT);

endmodule

// File: tb/tb_tc_pl_gset_relay_drv.sv
// Scoreboard bench for tc_pl_gset_relay_drv: directed requests push expected coil
// and completion events; a monitor pops and compares as the DUT produces them.
module tb_tc_pl_gset_relay_drv;
    import tc_pl_cap_pkg::*;

    localparam int NR = CAP0_14_DEF;
    localparam int CW = CAP0_2_DEF;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CW-1:0] cfg_pulse_len  = '0;
    logic [CW-1:0] cfg_settle_len = '0;
    logic [NR-1:0] relay_set, relay_rst, relay_state;
    logic          relay_valid;
    int            cyc = 0;

    tc_pl_gset_relay_drv_if #(.NR(NR)) gif ();

    tc_pl_gset_relay_drv #(.CAP0_14(NR), .CAP0_2(CW)) dut (
        .clk(clk), .rst(rst), .gset_if(gif),
        .cfg_pulse_len(cfg_pulse_len), .cfg_settle_len(cfg_settle_len),
        .relay_set(relay_set), .relay_rst(relay_rst),
        .relay_state(relay_state), .relay_valid(relay_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            is_cmpt;
        int            cyc;
        logic [NR-1:0] a;   // coil: set bits   / cmpt: relay_state
        logic [NR-1:0] b;   // coil: reset bits / cmpt: unused
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void push_coil(int c, logic [NR-1:0] s, logic [NR-1:0] r);
        exp_t e;
        e.is_cmpt = 1'b0; e.cyc = c; e.a = s; e.b = r;
        sb.push_back(e);
    endfunction

    function automatic void push_cmpt(int c, logic [NR-1:0] st);
        exp_t e;
        e.is_cmpt = 1'b1; e.cyc = c; e.a = st; e.b = '0;
        sb.push_back(e);
    endfunction

    // Expands hand-computed up/dn masks into per-cycle coil events and the completion cycle.
    function automatic void expect_req(int n, logic [NR-1:0] up, logic [NR-1:0] dn,
                                       int p, int s, logic [NR-1:0] st);
        int pp;
        pp = (p == 0) ? 1 : p;
        if ((up | dn) == '0) begin
            push_cmpt(n + 2, st);
        end else begin
`ifdef TC_RELAY_SEQ_EN
            int            base;
            int            k;
            logic [NR-1:0] m;
            base = n + 2;
            k    = 0;
            for (int b = 0; b < NR; b++) begin
                if (up[b] | dn[b]) begin
                    m    = '0;
                    m[b] = 1'b1;
                    for (int i = 0; i < pp; i++) push_coil(base + i, up & m, dn & m);
                    base += pp + 1;
                    k++;
                end
            end
            push_cmpt(n + 2 + k * (pp + 1) + s, st);
`else
            for (int i = 0; i < pp; i++) push_coil(n + 2 + i, up, dn);
            push_cmpt(n + 3 + pp + s, st);
`endif
        end
    endfunction

    task automatic request(logic [NR-1:0] code, int p, int s, output int n);
        @(negedge clk);
        cfg_pulse_len  = CW'(p);
        cfg_settle_len = CW'(s);
        gif.gset_relay = code;
        gif.gset_en    = 1'b1;
        n = cyc;
        @(negedge clk);
        gif.gset_relay = ~code;   // must be ignored once latched
    endtask

    task automatic wait_cmpt(string name);
        int t;
        t = 0;
        while (gif.gset_relay_cmpt !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_cmpt required=cmpt", name);
        end
    endtask

    task automatic release_req();
        @(negedge clk);
        gif.gset_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        gif.gset_en    = 1'b0;
        gif.gset_relay = '0;

        fork
            begin : monitor
                logic prev_cmpt;
                exp_t e;
                prev_cmpt = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        if ((relay_set | relay_rst) != '0) begin
                            chk("coil_overlap", relay_set & relay_rst, 0);
                            if (sb.size() == 0) begin
                                checks++;
                                failures++;
                                $display("FAIL unexpected_coil actual=set:%b,rst:%b required=none (cyc %0d)",
                                         relay_set, relay_rst, cyc);
                            end else begin
                                e = sb.pop_front();
                                chk("coil_kind", 0, e.is_cmpt);
                                chk("coil_cyc", cyc, e.cyc);
                                chk("coil_set", relay_set, e.a);
                                chk("coil_rst", relay_rst, e.b);
                            end
                        end
                        if (gif.gset_relay_cmpt && !prev_cmpt) begin
                            if (sb.size() == 0) begin
                                checks++;
                                failures++;
                                $display("FAIL unexpected_cmpt actual=1 required=0 (cyc %0d)", cyc);
                            end else begin
                                e = sb.pop_front();
                                chk("cmpt_kind", 1, e.is_cmpt);
                                chk("cmpt_cyc", cyc, e.cyc);
                                chk("cmpt_state", relay_state, e.a);
                                chk("cmpt_valid", relay_valid, 1);
                            end
                        end
                        prev_cmpt = gif.gset_relay_cmpt;
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_set", relay_set, 0);
        chk("rst_rst", relay_rst, 0);
        chk("rst_state", relay_state, 0);
        chk("rst_valid", relay_valid, 0);
        chk("rst_cmpt", gif.gset_relay_cmpt, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_coils", relay_set | relay_rst, 0);

        // First request, relay position unknown: every bit driven
        request(4'b1010, 4, 10, n);
        expect_req(n, 4'b1010, 4'b0101, 4, 10, 4'b1010);
        wait_cmpt("req1010");
        release_req();
        chk("valid_after_1010", relay_valid, 1);

        // Only changed bits are driven
        request(4'b0011, 4, 10, n);
        expect_req(n, 4'b0001, 4'b1000, 4, 10, 4'b0011);
        wait_cmpt("req0011");
        release_req();

        // Repeat of current code: no coil activity
        request(4'b0011, 4, 10, n);
        expect_req(n, 4'b0000, 4'b0000, 4, 10, 4'b0011);
        wait_cmpt("req0011_again");
        release_req();

        // Zero pulse length behaves as one cycle, zero settle
        request(4'b1100, 0, 0, n);
        expect_req(n, 4'b1100, 4'b0011, 0, 0, 4'b1100);
        wait_cmpt("req1100_p0");
        release_req();

        // Abort during pulse: only the first pulse cycle appears, no completion
        request(4'b0101, 4, 10, n);
`ifdef TC_RELAY_SEQ_EN
        push_coil(n + 2, 4'b0001, 4'b0000);
`else
        push_coil(n + 2, 4'b0001, 4'b1000);
`endif
        @(negedge clk);
        gif.gset_en = 1'b0;
        @(negedge clk);
        chk("abort_coils_off", relay_set | relay_rst, 0);
        repeat (4) @(negedge clk);
        chk("abort_valid", relay_valid, 0);
        chk("abort_cmpt", gif.gset_relay_cmpt, 0);

        // After abort every bit is driven again
        request(4'b0011, 4, 10, n);
        expect_req(n, 4'b0011, 4'b1100, 4, 10, 4'b0011);
        wait_cmpt("req0011_after_abort");
        release_req();

        request(4'b0101, 1, 2, n);
        expect_req(n, 4'b0100, 4'b0010, 1, 2, 4'b0101);
        wait_cmpt("req0101");
        release_req();

        // Full change 0101 -> 1010 with P=2, S=0
        request(4'b1010, 2, 0, n);
        expect_req(n, 4'b1010, 4'b0101, 2, 0, 4'b1010);
        wait_cmpt("req1010_full");
        release_req();

        repeat (5) @(negedge clk);
        chk("final_state", relay_state, 4'b1010);
        chk("final_valid", relay_valid, 1);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
